// File: rtl/alu_share_arbiter_if.sv
// Bundle of requester, response and ALU-side signals for alu_share_arbiter.
// The arbiter takes the slave view; whoever plays requesters and ALU takes master.
interface alu_share_arbiter_if #(
  parameter int WIDTH = 64
);
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [WIDTH-1:0] req0_x;
  logic [WIDTH-1:0] req0_y;
  logic [3:0]       req0_op;
  logic [WIDTH-1:0] req1_x;
  logic [WIDTH-1:0] req1_y;
  logic [3:0]       req1_op;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_zero;
  logic             rsp_err;
  logic [WIDTH-1:0] alu_x;
  logic [WIDTH-1:0] alu_y;
  logic [3:0]       alu_ctrl;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;
  logic             busy;

  modport slave (
    input  req_valid, req0_x, req0_y, req0_op, req1_x, req1_y, req1_op,
    input  rsp_ready, alu_result, alu_zero,
    output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err,
    output alu_x, alu_y, alu_ctrl, busy
  );

  modport master (
    output req_valid, req0_x, req0_y, req0_op, req1_x, req1_y, req1_op,
    output rsp_ready, alu_result, alu_zero,
    input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err,
    input  alu_x, alu_y, alu_ctrl, busy
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sequencer sharing one combinational ALU between two requesters.
//
//  state | meaning
//  IDLE  | no operation in flight, grant and accept one request
//  EXEC  | registered operands on the ALU, result captured at cycle end
//  RESP  | response held for the owner until it handshakes
module alu_share_arbiter #(
  parameter int WIDTH = 64
) (
  input logic               clk,
  input logic               reset,
  alu_share_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  state_t           next_state;
  logic             rr;
  logic             owner;
  logic             grant;
  logic             any_req;
  logic             op_legal;
  logic             rsp_done;
  logic [3:0]       sel_op;
  logic [WIDTH-1:0] sel_x;
  logic [WIDTH-1:0] sel_y;
  logic [1:0]       req_ready;
  logic [1:0]       rsp_valid;

  logic [WIDTH-1:0] alu_x_q;
  logic [WIDTH-1:0] alu_y_q;
  logic [3:0]       alu_ctrl_q;
  logic [WIDTH-1:0] rsp_result_q;
  logic             rsp_zero_q;
  logic             rsp_err_q;
  logic             busy_q;

  // Grant selection: a lone requester wins outright, a tie goes to rr.
  always_comb begin
    any_req = |bus.req_valid;
    grant   = 1'b0;
    case (bus.req_valid)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = rr;
      default: grant = 1'b0;
    endcase
    sel_x  = grant ? bus.req1_x  : bus.req0_x;
    sel_y  = grant ? bus.req1_y  : bus.req0_y;
    sel_op = grant ? bus.req1_op : bus.req0_op;
    case (sel_op)
      4'd0, 4'd1, 4'd2, 4'd6: op_legal = 1'b1;
      default:                op_legal = 1'b0;
    endcase
  end

  // Next-state and handshake decode; illegal ops skip EXEC so the ALU never sees them.
  always_comb begin
    next_state = state;
    req_ready  = 2'b00;
    rsp_valid  = 2'b00;
    rsp_done   = bus.rsp_ready[owner];
    case (state)
      IDLE: begin
        if (any_req) begin
          req_ready[grant] = 1'b1;
          next_state       = op_legal ? EXEC : RESP;
        end
      end
      EXEC: next_state = RESP;
      RESP: begin
        rsp_valid[owner] = 1'b1;
        if (rsp_done) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Operand latch, result capture, owner and round-robin pointer updates.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr           <= 1'b0;
      owner        <= 1'b0;
      alu_x_q      <= '0;
      alu_y_q      <= '0;
      alu_ctrl_q   <= '0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      busy_q <= (next_state != IDLE);
      case (state)
        IDLE: begin
          if (any_req) begin
            owner <= grant;
            if (op_legal) begin
              alu_x_q    <= sel_x;
              alu_y_q    <= sel_y;
              alu_ctrl_q <= sel_op;
            end else begin
              rsp_result_q <= '0;
              rsp_zero_q   <= 1'b0;
              rsp_err_q    <= 1'b1;
            end
          end
        end
        EXEC: begin
          rsp_result_q <= bus.alu_result;
          rsp_zero_q   <= bus.alu_zero;
          rsp_err_q    <= 1'b0;
        end
        RESP: begin
          if (rsp_done) rr <= ~owner;
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.rsp_valid  = rsp_valid;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_zero   = rsp_zero_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.alu_x      = alu_x_q;
  assign bus.alu_y      = alu_y_q;
  assign bus.alu_ctrl   = alu_ctrl_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural 64-bit ALU attached.
module tb_alu_share_arbiter;
  localparam int WIDTH = 64;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;
  logic [WIDTH-1:0] alu_res;

  alu_share_arbiter_if #(.WIDTH(WIDTH)) bus ();

  alu_share_arbiter #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The shared ALU itself: purely combinational.
  always_comb begin
    alu_res = '0;
    case (bus.alu_ctrl)
      4'd0:    alu_res = bus.alu_x & bus.alu_y;
      4'd1:    alu_res = bus.alu_x | bus.alu_y;
      4'd2:    alu_res = bus.alu_x + bus.alu_y;
      4'd6:    alu_res = bus.alu_x - bus.alu_y;
      default: alu_res = '0;
    endcase
    bus.alu_result = alu_res;
    bus.alu_zero   = (alu_res == '0);
  end

  task automatic clear_inputs();
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b00;
    bus.req0_x = '0; bus.req0_y = '0; bus.req0_op = 4'd0;
    bus.req1_x = '0; bus.req1_y = '0; bus.req1_op = 4'd0;
  endtask

  // Leaves the caller at a falling edge with reset just released.
  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    clear_inputs();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    vectors++; if (bus.req_ready !== 2'b00) begin miscompares++; $display("FAIL reset_req_ready: got %b want %b", bus.req_ready, 2'b00); end
    vectors++; if (bus.rsp_valid !== 2'b00) begin miscompares++; $display("FAIL reset_rsp_valid: got %b want %b", bus.rsp_valid, 2'b00); end
    vectors++; if ({bus.rsp_result, bus.rsp_zero, bus.rsp_err} !== {64'd0, 2'b00}) begin miscompares++; $display("FAIL reset_rsp_fields: got %h %b %b want 0 0 0", bus.rsp_result, bus.rsp_zero, bus.rsp_err); end
    vectors++; if ({bus.alu_x, bus.alu_y, bus.alu_ctrl} !== {64'd0, 64'd0, 4'd0}) begin miscompares++; $display("FAIL reset_alu_inputs: got %h %h %h want 0 0 0", bus.alu_x, bus.alu_y, bus.alu_ctrl); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_basic_add();
    apply_reset();
    bus.req_valid = 2'b01; bus.req0_op = 4'd2; bus.req0_x = 64'd5; bus.req0_y = 64'd7;
    #1;
    vectors++; if (bus.req_ready !== 2'b01) begin miscompares++; $display("FAIL basic_req_ready: got %b want %b", bus.req_ready, 2'b01); end
    @(negedge clk);
    bus.req_valid = 2'b00;
    #1;
    vectors++; if (bus.alu_ctrl !== 4'd2) begin miscompares++; $display("FAIL basic_alu_ctrl: got %0d want 2", bus.alu_ctrl); end
    vectors++; if ({bus.alu_x, bus.alu_y} !== {64'd5, 64'd7}) begin miscompares++; $display("FAIL basic_alu_operands: got %h %h want 5 7", bus.alu_x, bus.alu_y); end
    vectors++; if ({bus.busy, bus.rsp_valid} !== 3'b100) begin miscompares++; $display("FAIL basic_exec_flags: got busy=%b rsp_valid=%b want 1 00", bus.busy, bus.rsp_valid); end
    @(negedge clk);
    #1;
    vectors++; if (bus.rsp_valid !== 2'b01) begin miscompares++; $display("FAIL basic_rsp_valid: got %b want %b", bus.rsp_valid, 2'b01); end
    vectors++; if (bus.rsp_result !== 64'd12) begin miscompares++; $display("FAIL basic_rsp_result: got %0d want 12", bus.rsp_result); end
    vectors++; if ({bus.rsp_zero, bus.rsp_err} !== 2'b00) begin miscompares++; $display("FAIL basic_rsp_flags: got zero=%b err=%b want 0 0", bus.rsp_zero, bus.rsp_err); end
    bus.rsp_ready = 2'b01;
    @(negedge clk);
    bus.rsp_ready = 2'b00;
    #1;
    vectors++; if ({bus.rsp_valid, bus.busy} !== 3'b000) begin miscompares++; $display("FAIL basic_after_handshake: got rsp_valid=%b busy=%b want 00 0", bus.rsp_valid, bus.busy); end
  endtask

  task automatic test_round_robin();
    apply_reset();
    bus.req_valid = 2'b11;
    bus.req0_op = 4'd6; bus.req0_x = 64'd9;    bus.req0_y = 64'd9;
    bus.req1_op = 4'd1; bus.req1_x = 64'hF0;   bus.req1_y = 64'h0F;
    #1;
    vectors++; if (bus.req_ready !== 2'b01) begin miscompares++; $display("FAIL rr_first_grant: got %b want %b", bus.req_ready, 2'b01); end
    @(negedge clk);
    #1;
    vectors++; if (bus.req_ready !== 2'b00) begin miscompares++; $display("FAIL rr_exec_no_ready: got %b want %b", bus.req_ready, 2'b00); end
    @(negedge clk);
    #1;
    vectors++; if ({bus.rsp_valid, bus.rsp_result, bus.rsp_zero} !== {2'b01, 64'd0, 1'b1}) begin miscompares++; $display("FAIL rr_req0_rsp: got %b %h %b want 01 0 1", bus.rsp_valid, bus.rsp_result, bus.rsp_zero); end
    bus.rsp_ready = 2'b01;
    @(negedge clk);
    bus.rsp_ready = 2'b00;
    #1;
    vectors++; if (bus.req_ready !== 2'b10) begin miscompares++; $display("FAIL rr_second_grant: got %b want %b", bus.req_ready, 2'b10); end
    @(negedge clk);
    bus.req_valid = 2'b00;
    @(negedge clk);
    #1;
    vectors++; if ({bus.rsp_valid, bus.rsp_result, bus.rsp_zero} !== {2'b10, 64'hFF, 1'b0}) begin miscompares++; $display("FAIL rr_req1_rsp: got %b %h %b want 10 ff 0", bus.rsp_valid, bus.rsp_result, bus.rsp_zero); end
    bus.rsp_ready = 2'b10;
    @(negedge clk);
    bus.rsp_ready = 2'b00;
    bus.req_valid = 2'b11;
    #1;
    vectors++; if (bus.req_ready !== 2'b01) begin miscompares++; $display("FAIL rr_pointer_back_to_0: got %b want %b", bus.req_ready, 2'b01); end
    bus.req_valid = 2'b00;
  endtask

  task automatic test_backpressure();
    apply_reset();
    bus.req_valid = 2'b01; bus.req0_op = 4'd2; bus.req0_x = 64'd3; bus.req0_y = 64'd4;
    bus.req1_op = 4'd0; bus.req1_x = 64'hFF; bus.req1_y = 64'h0F;
    @(negedge clk);
    bus.req_valid = 2'b11;
    // rsp_ready held low while the owner's response waits
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      vectors++; if ({bus.rsp_valid, bus.rsp_result} !== {2'b01, 64'd7}) begin miscompares++; $display("FAIL bp_hold_rsp[%0d]: got %b %h want 01 7", i, bus.rsp_valid, bus.rsp_result); end
      vectors++; if ({bus.req_ready, bus.busy} !== 3'b001) begin miscompares++; $display("FAIL bp_hold_ready_busy[%0d]: got ready=%b busy=%b want 00 1", i, bus.req_ready, bus.busy); end
    end
    // non-owner readiness must not complete the response
    bus.rsp_ready = 2'b10;
    @(negedge clk);
    #1;
    vectors++; if (bus.rsp_valid !== 2'b01) begin miscompares++; $display("FAIL bp_non_owner_ready: got %b want %b", bus.rsp_valid, 2'b01); end
    bus.rsp_ready = 2'b01;
    @(negedge clk);
    bus.rsp_ready = 2'b00;
    #1;
    vectors++; if ({bus.rsp_valid, bus.busy, bus.req_ready} !== 5'b00010) begin miscompares++; $display("FAIL bp_resume: got rsp_valid=%b busy=%b ready=%b want 00 0 10", bus.rsp_valid, bus.busy, bus.req_ready); end
    bus.req_valid = 2'b00;
  endtask

  task automatic test_illegal_op();
    apply_reset();
    bus.req_valid = 2'b01; bus.req0_op = 4'd2; bus.req0_x = 64'h10; bus.req0_y = 64'h20;
    @(negedge clk);
    bus.req_valid = 2'b00;
    @(negedge clk);
    bus.rsp_ready = 2'b01;
    @(negedge clk);
    bus.rsp_ready = 2'b00;
    bus.req_valid = 2'b10; bus.req1_op = 4'd5; bus.req1_x = 64'hAA; bus.req1_y = 64'hBB;
    #1;
    vectors++; if (bus.req_ready !== 2'b10) begin miscompares++; $display("FAIL illegal_accept: got %b want %b", bus.req_ready, 2'b10); end
    @(negedge clk);
    bus.req_valid = 2'b00;
    #1;
    vectors++; if ({bus.rsp_valid, bus.rsp_err, bus.rsp_zero} !== 4'b1010) begin miscompares++; $display("FAIL illegal_rsp_flags: got valid=%b err=%b zero=%b want 10 1 0", bus.rsp_valid, bus.rsp_err, bus.rsp_zero); end
    vectors++; if (bus.rsp_result !== 64'd0) begin miscompares++; $display("FAIL illegal_rsp_result: got %h want 0", bus.rsp_result); end
    vectors++; if ({bus.alu_ctrl, bus.alu_x, bus.alu_y} !== {4'd2, 64'h10, 64'h20}) begin miscompares++; $display("FAIL illegal_alu_unchanged: got %h %h %h want 2 10 20", bus.alu_ctrl, bus.alu_x, bus.alu_y); end
    bus.rsp_ready = 2'b10;
    @(negedge clk);
    bus.rsp_ready = 2'b00;
    bus.req_valid = 2'b10; bus.req1_op = 4'd0; bus.req1_x = 64'hF0F0; bus.req1_y = 64'hFF00;
    @(negedge clk);
    bus.req_valid = 2'b00;
    #1;
    vectors++; if (bus.alu_ctrl !== 4'd0) begin miscompares++; $display("FAIL illegal_next_alu_ctrl: got %0d want 0", bus.alu_ctrl); end
    @(negedge clk);
    #1;
    vectors++; if ({bus.rsp_valid, bus.rsp_err, bus.rsp_result} !== {2'b10, 1'b0, 64'hF000}) begin miscompares++; $display("FAIL illegal_followup_rsp: got %b %b %h want 10 0 f000", bus.rsp_valid, bus.rsp_err, bus.rsp_result); end
    bus.rsp_ready = 2'b10;
    @(negedge clk);
    bus.rsp_ready = 2'b00;
  endtask

  task automatic test_reset_in_exec();
    apply_reset();
    bus.req_valid = 2'b01; bus.req0_op = 4'd6; bus.req0_x = 64'd100; bus.req0_y = 64'd1;
    @(negedge clk);
    bus.req_valid = 2'b00;
    #1;
    vectors++; if ({bus.busy, bus.alu_x} !== {1'b1, 64'd100}) begin miscompares++; $display("FAIL rst_exec_entry: got busy=%b alu_x=%h want 1 64", bus.busy, bus.alu_x); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    vectors++; if ({bus.rsp_valid, bus.req_ready, bus.busy} !== 5'b00000) begin miscompares++; $display("FAIL rst_exec_flags: got rsp_valid=%b ready=%b busy=%b want 00 00 0", bus.rsp_valid, bus.req_ready, bus.busy); end
    vectors++; if ({bus.alu_x, bus.alu_y, bus.alu_ctrl, bus.rsp_result, bus.rsp_zero, bus.rsp_err} !== '0) begin miscompares++; $display("FAIL rst_exec_regs: got %h %h %h %h %b %b want all 0", bus.alu_x, bus.alu_y, bus.alu_ctrl, bus.rsp_result, bus.rsp_zero, bus.rsp_err); end
    @(negedge clk);
    #1;
    vectors++; if (bus.rsp_valid !== 2'b00) begin miscompares++; $display("FAIL rst_exec_no_pulse: got %b want %b", bus.rsp_valid, 2'b00); end
    bus.req_valid = 2'b10; bus.req1_op = 4'd2; bus.req1_x = 64'd20; bus.req1_y = 64'd22;
    #1;
    vectors++; if (bus.req_ready !== 2'b10) begin miscompares++; $display("FAIL rst_exec_new_accept: got %b want %b", bus.req_ready, 2'b10); end
    @(negedge clk);
    bus.req_valid = 2'b00;
    @(negedge clk);
    #1;
    vectors++; if ({bus.rsp_valid, bus.rsp_result} !== {2'b10, 64'd42}) begin miscompares++; $display("FAIL rst_exec_new_rsp: got %b %0d want 10 42", bus.rsp_valid, bus.rsp_result); end
    bus.rsp_ready = 2'b10;
    @(negedge clk);
    bus.rsp_ready = 2'b00;
  endtask

  task automatic test_add_carry();
    apply_reset();
    bus.req_valid = 2'b01; bus.req0_op = 4'd2; bus.req0_x = 64'hFFFF_FFFF_FFFF_FFFF; bus.req0_y = 64'd1;
    @(negedge clk);
    bus.req_valid = 2'b00;
    @(negedge clk);
    #1;
    vectors++; if ({bus.rsp_valid, bus.rsp_result, bus.rsp_zero} !== {2'b01, 64'd0, 1'b1}) begin miscompares++; $display("FAIL carry_wrap: got %b %h %b want 01 0 1", bus.rsp_valid, bus.rsp_result, bus.rsp_zero); end
    bus.rsp_ready = 2'b01;
    @(negedge clk);
    bus.rsp_ready = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_basic_add();
    test_round_robin();
    test_backpressure();
    test_illegal_op();
    test_reset_in_exec();
    test_add_carry();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
